// File: rtl/am_burst_scheduler_if.sv
// Handshake bundle between the distance path, the burst scheduler and the AM DAC.
// The scheduler uses the slave modport; the distance source/DAC side uses master.
interface am_burst_scheduler_if #(
  parameter int WIDTH = 13
);
  logic             run;
  logic [WIDTH-1:0] distance;
  logic             distance_valid;
  logic             dac_enable;
  logic [WIDTH-1:0] dac_distance;
  logic             busy;
  logic             burst_start;

  modport master (
    output run, distance, distance_valid,
    input  dac_enable, dac_distance, busy, burst_start
  );

  modport slave (
    input  run, distance, distance_valid,
    output dac_enable, dac_distance, busy, burst_start
  );
endinterface

// File: rtl/am_burst_scheduler.sv
// Parking-sensor beeper: turns distance samples into DAC tone bursts whose gap shrinks with distance.
// Outputs are registered one cycle behind the state register; no backpressure, samples are strobes.
module am_burst_scheduler #(
  parameter int WIDTH         = 13,
  parameter int LOG2_MAX_DIST = 11,
  parameter int TICK_DIV      = 50000,
  parameter int ON_TICKS      = 50,
  parameter int OFF_SHIFT     = 3,
  parameter int CONT_DIST     = 64
) (
  input logic             clk,
  input logic             reset,
  am_burst_scheduler_if.slave bus
);

  localparam int OFF_MAX = (2 ** LOG2_MAX_DIST) >> OFF_SHIFT;
  localparam int CNT_MAX = (ON_TICKS > OFF_MAX) ? ON_TICKS : OFF_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(TICK_DIV);

  localparam logic [WIDTH:0]  MAX_DIST_W = (WIDTH + 1)'(2 ** LOG2_MAX_DIST);
  localparam logic [WIDTH:0]  CONT_W     = (WIDTH + 1)'(CONT_DIST);
  localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   ON_LOAD    = CW'(ON_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] latched_q, latched_d;
  logic [WIDTH-1:0] shadow_q;
  logic             have_q;
  logic             start_q, start_d;
  logic             dac_enable_q;
  logic [WIDTH-1:0] dac_distance_q;
  logic             busy_q;
  logic             burst_start_q;

  logic [WIDTH-1:0] eff;
  logic             eff_ok;
  logic             eff_cont;
  logic             lat_cont;
  logic             tick;
  logic             go_on;
  logic [WIDTH-1:0] off_ticks;
  logic [CW-1:0]    off_load;

  always_comb begin
    eff       = bus.distance_valid ? bus.distance : shadow_q;
    eff_ok    = {1'b0, eff} < MAX_DIST_W;
    eff_cont  = {1'b0, eff} < CONT_W;
    lat_cont  = {1'b0, latched_q} < CONT_W;
    tick      = (state_q != S_IDLE) && (presc_q == TICK_LAST);
    off_ticks = latched_q >> OFF_SHIFT;
    // OFF time is floored at one tick, so a zero shift result loads the same as one.
    off_load  = (off_ticks == '0) ? '0 : CW'(off_ticks - WIDTH'(1));

    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    cnt_d     = cnt_q;
    latched_d = latched_q;
    start_d   = 1'b0;
    go_on     = 1'b0;

    if (!bus.run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((have_q || bus.distance_valid) && eff_ok) go_on = 1'b1;
        end
        S_ON: begin
          if (tick) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
            end else if (!eff_ok) begin
              state_d = S_IDLE;
            end else if (lat_cont && eff_cont) begin
              go_on = 1'b1;
            end else begin
              state_d = S_OFF;
              cnt_d   = off_load;
            end
          end
        end
        S_OFF: begin
          if (tick) begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else if (!eff_ok) state_d = S_IDLE;
            else go_on = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (go_on) begin
      state_d   = S_ON;
      latched_d = eff;
      cnt_d     = ON_LOAD;
      start_d   = 1'b1;
    end

    // Every state entry (including ON re-entry) restarts the tick phase.
    if (go_on || (state_d != state_q) || (state_d == S_IDLE)) presc_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      presc_q        <= '0;
      cnt_q          <= '0;
      latched_q      <= '0;
      shadow_q       <= '0;
      have_q         <= 1'b0;
      start_q        <= 1'b0;
      dac_enable_q   <= 1'b0;
      dac_distance_q <= '0;
      busy_q         <= 1'b0;
      burst_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      cnt_q         <= cnt_d;
      latched_q     <= latched_d;
      start_q       <= start_d;
      dac_enable_q  <= (state_q == S_ON);
      busy_q        <= (state_q != S_IDLE);
      burst_start_q <= start_q;
      if (state_q == S_ON) dac_distance_q <= latched_q;
      if (bus.distance_valid) begin
        shadow_q <= bus.distance;
        have_q   <= 1'b1;
      end
    end
  end

  assign bus.dac_enable   = dac_enable_q;
  assign bus.dac_distance = dac_distance_q;
  assign bus.busy         = busy_q;
  assign bus.burst_start  = burst_start_q;

endmodule

// File: tb/tb_am_burst_scheduler.sv
// Directed and randomized checks of am_burst_scheduler against a phase-length reference model.
// A second instance with CONT_DIST=0 covers the one-tick OFF floor.
module tb_am_burst_scheduler;
  localparam int TD   = 4;
  localparam int ONT  = 2;
  localparam int SH   = 3;
  localparam int CONT = 64;
  localparam int MAXD = 2048;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  am_burst_scheduler_if #(.WIDTH(13)) bus ();
  am_burst_scheduler_if #(.WIDTH(13)) bus2 ();

  am_burst_scheduler #(
    .WIDTH(13), .LOG2_MAX_DIST(11), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_SHIFT(SH), .CONT_DIST(CONT)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  am_burst_scheduler #(
    .WIDTH(13), .LOG2_MAX_DIST(11), .TICK_DIV(TD), .ON_TICKS(ONT), .OFF_SHIFT(SH), .CONT_DIST(0)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  // Reference model: phase kind plus cycles left in the phase.
  int m_st;     // 0 idle, 1 tone on, 2 tone off
  int m_left;
  int m_lat;
  int m_sh;
  bit m_have;
  bit m_start;
  int e_en, e_dist, e_busy, e_bs;

  bit prev_en;
  int rises[$];
  int falls[$];
  int rise_dist[$];
  int bs_cnt;
  bit chk2;
  int s2;
  int s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_left = 0; m_lat = 0; m_sh = 0; m_have = 0; m_start = 0;
    e_en = 0; e_dist = 0; e_busy = 0; e_bs = 0;
    prev_en = 0;
  endtask

  task automatic clr();
    rises.delete(); falls.delete(); rise_dist.delete();
    bs_cnt = 0;
  endtask

  task automatic drive(input bit r, input bit v, input int d);
    bus.run  = r; bus.distance_valid  = v; bus.distance  = 13'(d);
    bus2.run = r; bus2.distance_valid = v; bus2.distance = 13'(d);
  endtask

  task automatic cyc(input bit r, input bit v, input int d);
    int eff, n_en, n_busy, n_bs, n_dist, k, off;
    bit ok, go;
    drive(r, v, d);
    eff    = v ? d : m_sh;
    ok     = eff < MAXD;
    n_en   = (m_st == 1) ? 1 : 0;
    n_busy = (m_st != 0) ? 1 : 0;
    n_bs   = m_start ? 1 : 0;
    n_dist = (m_st == 1) ? m_lat : e_dist;
    go     = 0;
    if (!r) m_st = 0;
    else if (m_st == 0) begin
      if ((m_have || v) && ok) go = 1;
    end else if (m_left > 1) m_left--;
    else if (!ok) m_st = 0;
    else if (m_st == 1 && !(m_lat < CONT && eff < CONT)) begin
      off    = m_lat >> SH;
      m_st   = 2;
      m_left = ((off > 0) ? off : 1) * TD;
    end else go = 1;
    m_start = go;
    if (go) begin
      m_st = 1; m_left = ONT * TD; m_lat = eff;
    end
    if (v) begin
      m_sh = d; m_have = 1;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    e_en = n_en; e_busy = n_busy; e_bs = n_bs; e_dist = n_dist;
    chk("dac_enable",   32'(bus.dac_enable),   e_en);
    chk("dac_distance", 32'(bus.dac_distance), e_dist);
    chk("busy",         32'(bus.busy),         e_busy);
    chk("burst_start",  32'(bus.burst_start),  e_bs);
    if (bus.dac_enable && !prev_en) begin
      rises.push_back(cyc_n);
      rise_dist.push_back(int'(bus.dac_distance));
    end
    if (!bus.dac_enable && prev_en) falls.push_back(cyc_n);
    prev_en = bus.dac_enable;
    if (bus.burst_start) bs_cnt++;
    if (chk2) begin
      k = cyc_n - s2 - 2;
      chk("dut2_enable", 32'(bus2.dac_enable),  (k >= 0 && (k % 12) < 8) ? 1 : 0);
      chk("dut2_bstart", 32'(bus2.burst_start), (k >= 0 && (k % 12) == 0) ? 1 : 0);
    end
  endtask

  // Reset is raised between clock edges; outputs must clear before any edge.
  task automatic do_reset();
    drive(0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rst_enable", 32'(bus.dac_enable),   0);
    chk("rst_busy",   32'(bus.busy),         0);
    chk("rst_bstart", 32'(bus.burst_start),  0);
    chk("rst_dist",   32'(bus.dac_distance), 0);
    chk("rst_enable2", 32'(bus2.dac_enable), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    int c, d;
    bit r, v;
    reset = 1'b0;
    chk2  = 0;
    s2    = 0;
    m_reset();
    clr();
    do_reset();

    // Far target: 8-cycle bursts separated by 50 ticks of silence.
    clr(); s = cyc_n;
    cyc(1, 1, 400);
    repeat (214) cyc(1, 0, 0);
    chk("s1_rise0", rises[0], s + 2);
    chk("s1_fall0", falls[0], s + 10);
    chk("s1_rise1", rises[1], s + 210);
    chk("s1_bstarts", bs_cnt, 2);
    chk("s1_dist", 32'(bus.dac_distance), 400);

    // Close target: continuous tone with a burst_start every 8 cycles.
    do_reset(); clr(); s = cyc_n;
    cyc(1, 1, 40);
    repeat (39) cyc(1, 0, 0);
    chk("s2_rises", rises.size(), 1);
    chk("s2_falls", falls.size(), 0);
    chk("s2_bstarts", bs_cnt, 5);
    chk("s2_dist", 32'(bus.dac_distance), 40);

    // Mid-burst sample only affects the next burst.
    do_reset(); clr(); s = cyc_n;
    cyc(1, 1, 400);
    repeat (4) cyc(1, 0, 0);
    cyc(1, 1, 100);
    cyc(1, 0, 0);
    chk("s3_hold", 32'(bus.dac_distance), 400);
    repeat (263) cyc(1, 0, 0);
    chk("s3_fall0", falls[0], s + 10);
    chk("s3_rise1", rises[1], s + 210);
    chk("s3_fall1", falls[1], s + 218);
    chk("s3_rise2", rises[2], s + 266);
    chk("s3_dist0", rise_dist[0], 400);
    chk("s3_dist1", rise_dist[1], 100);

    // Out-of-range sample during OFF: silence after OFF ends, later sample restarts.
    do_reset(); clr(); s = cyc_n;
    cyc(1, 1, 400);
    repeat (19) cyc(1, 0, 0);
    cyc(1, 1, 3000);
    repeat (194) cyc(1, 0, 0);
    chk("s4_busy", 32'(bus.busy), 0);
    chk("s4_enable", 32'(bus.dac_enable), 0);
    chk("s4_rises", rises.size(), 1);
    cyc(1, 1, 500);
    cyc(1, 0, 0);
    chk("s4_restart_en", 32'(bus.dac_enable), 1);
    chk("s4_restart_dist", 32'(bus.dac_distance), 500);

    // Distance 4: continuous on the main instance, 1-tick OFF on the CONT_DIST=0 instance.
    do_reset(); clr(); s2 = cyc_n; chk2 = 1;
    cyc(1, 1, 4);
    repeat (35) cyc(1, 0, 0);
    chk2 = 0;
    chk("s5_cont_falls", falls.size(), 0);

    // Range edge: 2047 plays, 2048 is silent.
    do_reset();
    cyc(1, 1, 2047);
    cyc(1, 0, 0);
    chk("edge_2047_en", 32'(bus.dac_enable), 1);
    do_reset();
    cyc(1, 1, 2048);
    cyc(1, 0, 0);
    chk("edge_2048_busy", 32'(bus.busy), 0);

    // run dropped mid-ON: enable falls one edge after run=0 is sampled.
    do_reset();
    cyc(1, 1, 400);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("s6_run_hold", 32'(bus.dac_enable), 1);
    cyc(0, 0, 0);
    chk("s6_run_off", 32'(bus.dac_enable), 0);
    chk("s6_run_busy", 32'(bus.busy), 0);

    // Asynchronous reset while the tone is on.
    cyc(1, 1, 400);
    repeat (3) cyc(1, 0, 0);
    chk("s6_pre_rst", 32'(bus.dac_enable), 1);
    do_reset();

    repeat (3000) begin
      r = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 39) == 0);
      c = int'($urandom_range(0, 9));
      if (c < 4) d = int'($urandom_range(0, 80));
      else if (c < 7) d = int'($urandom_range(0, 400));
      else if (c == 7) begin
        case ($urandom_range(0, 3))
          0:       d = 63;
          1:       d = 64;
          2:       d = 2047;
          default: d = 2048;
        endcase
      end else if (c == 8) d = int'($urandom_range(2048, 8191));
      else d = int'($urandom_range(0, 8191));
      cyc(r, v, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/am_burst_scheduler.md
Name: am_burst_scheduler

Overview:
- Sequences the AM carrier DAC as a parking-sensor style beeper.
- Converts a stream of distance samples into on/off tone bursts. The burst repetition interval shrinks as distance shrinks, and the tone becomes continuous when very close.
- Drives the DAC's enable and distance inputs. Sits between the distance measurement path and the AM DAC, in the same clock domain.

Parameters:
- WIDTH, 13, bit width of distance in/out.
- LOG2_MAX_DIST, 11, MAX_DIST = 2**LOG2_MAX_DIST; distances >= MAX_DIST are out of range (silence).
- TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); must be >= 2.
- ON_TICKS, 50, burst length in ticks; must be >= 1.
- OFF_SHIFT, 3, off time in ticks = distance >> OFF_SHIFT, floored at 1.
- CONT_DIST, 64, distances < CONT_DIST give a continuous tone.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  level; 1 = beeper allowed to operate
- distance  input  WIDTH  new distance sample
- distance_valid  input  1  one-cycle strobe qualifying distance
- dac_enable  output  1  registered; drives AM DAC enable
- dac_distance  output  WIDTH  registered; drives AM DAC distance
- busy  output  1  registered; 1 whenever state != IDLE
- burst_start  output  1  registered one-cycle pulse on each entry to ON

Behaviour:
- Reset (async, active-high): state=IDLE; shadow=0; have_dist=0; latched=0; prescaler=0; tick counter=0; all outputs 0. Reset mid-burst silences the DAC immediately, with no wait for a clock edge.
- Shadow register:
  - Captures distance on every distance_valid, in any state.
  - Sets have_dist=1.
- Eligible value: eff = distance if distance_valid is high this cycle, else shadow (same-cycle bypass).
- Prescaler:
  - Counts 0..TICK_DIV-1 while in ON or OFF. A tick is produced when it reaches TICK_DIV-1, and it then wraps to 0.
  - Cleared on every state entry.
  - Held at 0 in IDLE.
- State IDLE:
  - Goes to ON when run && (have_dist || distance_valid) && eff < MAX_DIST.
  - Otherwise stays in IDLE.
- Entry to ON (from any state):
  - latched <= eff; tick counter <= ON_TICKS-1.
  - Next cycle: dac_enable=1, dac_distance=latched, burst_start=1 for exactly 1 cycle.
- State ON:
  - dac_enable=1. dac_distance stays constant (latched) for the whole burst; mid-burst samples go only to the shadow.
  - On a tick with tick counter=0, re-evaluate eff:
    - eff >= MAX_DIST -> IDLE.
    - Else if latched < CONT_DIST and eff < CONT_DIST -> re-enter ON (re-latch). dac_enable stays high with no gap, and burst_start pulses again.
    - Else -> OFF, with tick counter <= max(1, latched >> OFF_SHIFT) - 1.
  - On a tick with tick counter != 0: decrement the tick counter.
- State OFF:
  - dac_enable=0; dac_distance holds its last value.
  - On a tick with tick counter=0: if eff >= MAX_DIST -> IDLE, else -> ON.
  - Otherwise decrement the tick counter on each tick.
- Timing:
  - ON lasts exactly ON_TICKS*TICK_DIV cycles.
  - OFF lasts exactly max(1, latched>>OFF_SHIFT)*TICK_DIV cycles.
  - IDLE->ON decision to dac_enable=1 is 1 cycle of latency.
- run=0 in any state: next state is IDLE, and dac_enable=0 on the following edge. Any burst in progress is abandoned. This rule has priority over every other transition.
- Simultaneous events:
  - run falling together with a tick end: IDLE wins.
  - distance_valid together with a burst-boundary evaluation: the new distance is used.
- Out-of-range sample arriving mid-burst: the current ON/OFF completes, then the block goes to IDLE.
- busy=1 in ON and OFF, 0 in IDLE.
- Widths: latched>>OFF_SHIFT is computed at WIDTH bits. The tick counter must hold max(ON_TICKS, MAX_DIST>>OFF_SHIFT) with no overflow.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_SHIFT=3, CONT_DIST=64, LOG2_MAX_DIST=11):
- Reset then run=1, distance=400 with valid pulse at cycle 0 -> dac_enable rises at cycle 2, dac_distance=400, burst_start 1 cycle. dac_enable high 8 cycles, low 200 cycles (50 ticks), then rises again with burst_start.
- run=1, distance=40 -> dac_enable continuously high. burst_start pulses every 8 cycles; dac_distance=40.
- Mid-burst sample 100 after a burst at 400 -> dac_distance stays 400 through ON. The following OFF is 200 cycles; the next ON shows 100, and its OFF is 48 cycles.
- Sample 3000 during OFF -> after the OFF completes, state=IDLE, busy=0, dac_enable stays 0. A later sample of 500 restarts bursts.
- Distance=4 in the non-continuous case (CONT_DIST temporarily 0) -> OFF floored to 1 tick = 4 cycles.
- Assert reset asynchronously mid-ON -> dac_enable/busy go to 0 with no clock edge. run deasserted mid-ON -> dac_enable=0 on the next edge after the edge where run=0 is sampled.
